// File: rtl/game2048_pkg.sv
// Shared constants for the 2048 board renderer: VGA timing, board geometry,
// palette and the cell-index helper.
package game2048_pkg;

    localparam int NUM_WIDTH = 4;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int ORIGIN_X = 95;
    localparam int ORIGIN_Y = 15;
    localparam int TILE     = 100;
    localparam int GAP      = 10;

    localparam logic [11:0] BG_SCREEN = 12'hFEE;
    localparam logic [11:0] BG_BOARD  = 12'hBAA;

    // Exponents 11..15 share the top colour.
    localparam logic [11:0] TILE_LUT [16] = '{
        12'hCBA, 12'hEED, 12'hEEC, 12'hFB7,
        12'hF96, 12'hF75, 12'hF53, 12'hEC7,
        12'hEC6, 12'hEC5, 12'hEC3, 12'hEC2,
        12'hEC2, 12'hEC2, 12'hEC2, 12'hEC2
    };

    typedef enum logic [1:0] {
        PX_BLANK,
        PX_SCREEN,
        PX_BOARD,
        PX_TILE
    } px_class_t;

    function automatic logic [3:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
        return {r, c};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running VGA h/v counters with raw sync, active and frame-end flags.
// Everything advances only on the pixel strobe.
module vga_timing #(
    parameter int H_ACTIVE = game2048_pkg::H_ACTIVE,
    parameter int H_FP     = game2048_pkg::H_FP,
    parameter int H_SYNC   = game2048_pkg::H_SYNC,
    parameter int H_BP     = game2048_pkg::H_BP,
    parameter int V_ACTIVE = game2048_pkg::V_ACTIVE,
    parameter int V_FP     = game2048_pkg::V_FP,
    parameter int V_SYNC   = game2048_pkg::V_SYNC,
    parameter int V_BP     = game2048_pkg::V_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       frame_end
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign hsync     = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vsync     = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    assign active    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/board_vga_renderer.sv
// Draws the 4x4 2048 board as coloured tiles on a VGA raster. The board is
// snapshotted once per frame so a move landing mid-frame never tears.
module board_vga_renderer #(
    parameter int NUM_WIDTH = game2048_pkg::NUM_WIDTH,
    parameter int H_ACTIVE  = game2048_pkg::H_ACTIVE,
    parameter int H_FP      = game2048_pkg::H_FP,
    parameter int H_SYNC    = game2048_pkg::H_SYNC,
    parameter int H_BP      = game2048_pkg::H_BP,
    parameter int V_ACTIVE  = game2048_pkg::V_ACTIVE,
    parameter int V_FP      = game2048_pkg::V_FP,
    parameter int V_SYNC    = game2048_pkg::V_SYNC,
    parameter int V_BP      = game2048_pkg::V_BP,
    parameter int ORIGIN_X  = game2048_pkg::ORIGIN_X,
    parameter int ORIGIN_Y  = game2048_pkg::ORIGIN_Y,
    parameter int TILE      = game2048_pkg::TILE,
    parameter int GAP       = game2048_pkg::GAP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_en,
    input  logic [NUM_WIDTH*16-1:0] board_in,
    output logic                    hsync,
    output logic                    vsync,
    output logic [11:0]             rgb,
    output logic                    frame_start
);

    import game2048_pkg::*;

    localparam int PITCH = TILE + GAP;
    localparam int BOX   = 4 * TILE + 5 * GAP;
    localparam int COL0  = ORIGIN_X + GAP;
    localparam int ROW0  = ORIGIN_Y + GAP;

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       hs_raw;
    logic       vs_raw;
    logic       active;
    logic       frame_end;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .hsync     (hs_raw),
        .vsync     (vs_raw),
        .active    (active),
        .frame_end (frame_end)
    );

    logic [NUM_WIDTH*16-1:0] snapshot;
    int                      x;
    int                      y;
    logic [3:0]              col_hit;
    logic [3:0]              row_hit;
    logic [1:0]              col;
    logic [1:0]              row;
    logic                    in_box;
    px_class_t               cls;
    px_class_t               cls1;
    logic [3:0]              cell1;
    logic                    hs1;
    logic                    vs1;
    logic [NUM_WIDTH-1:0]    exp_sel;
    logic [11:0]             colour;

    assign x = int'(h_cnt);
    assign y = int'(v_cnt);

    // Constant range compares per column/row instead of dividing by PITCH.
    always_comb begin
        col_hit = '0;
        row_hit = '0;
        for (int i = 0; i < 4; i++) begin
            col_hit[i] = (x >= COL0 + i * PITCH) && (x < COL0 + i * PITCH + TILE);
            row_hit[i] = (y >= ROW0 + i * PITCH) && (y < ROW0 + i * PITCH + TILE);
        end
    end

    always_comb begin
        col = 2'd0;
        unique case (1'b1)
            col_hit[1]: col = 2'd1;
            col_hit[2]: col = 2'd2;
            col_hit[3]: col = 2'd3;
            default:    col = 2'd0;
        endcase
    end

    always_comb begin
        row = 2'd0;
        unique case (1'b1)
            row_hit[1]: row = 2'd1;
            row_hit[2]: row = 2'd2;
            row_hit[3]: row = 2'd3;
            default:    row = 2'd0;
        endcase
    end

    assign in_box = (x >= ORIGIN_X) && (x < ORIGIN_X + BOX) &&
                    (y >= ORIGIN_Y) && (y < ORIGIN_Y + BOX);

    always_comb begin
        cls = PX_BLANK;
        if (active) begin
            if ((|col_hit) && (|row_hit)) cls = PX_TILE;
            else if (in_box)              cls = PX_BOARD;
            else                          cls = PX_SCREEN;
        end
    end

    assign exp_sel = snapshot[cell1 * NUM_WIDTH +: NUM_WIDTH];

    always_comb begin
        colour = 12'h000;
        unique case (cls1)
            PX_SCREEN: colour = BG_SCREEN;
            PX_BOARD:  colour = BG_BOARD;
            PX_TILE:   colour = TILE_LUT[4'(exp_sel)];
            default:   colour = 12'h000;
        endcase
    end

    // Stage 1 holds the pixel class, stage 2 the colour; sync rides alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            snapshot    <= '0;
            frame_start <= 1'b0;
            cls1        <= PX_BLANK;
            cell1       <= '0;
            hs1         <= 1'b1;
            vs1         <= 1'b1;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            rgb         <= '0;
        end else begin
            frame_start <= pix_en && frame_end;
            if (pix_en) begin
                if (frame_end) snapshot <= board_in;
                cls1  <= cls;
                cell1 <= cell_idx(row, col);
                hs1   <= hs_raw;
                vs1   <= vs_raw;
                hsync <= hs1;
                vsync <= vs1;
                rgb   <= colour;
            end
        end
    end

endmodule

// File: tb/tb_board_vga_renderer.sv
// Directed bench: full-size instance for line timing, a shrunken instance
// for frame-level snapshot, colour, pause and reset behaviour.
module tb_board_vga_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pe_d;
    logic        pe_s;
    logic [63:0] board_d;
    logic [63:0] board_s;
    logic        hsync_d, vsync_d, fs_d;
    logic        hsync_s, vsync_s, fs_s;
    logic [11:0] rgb_d, rgb_s;

    int vec  = 0;
    int miss = 0;
    int nd   = 0;
    int ns   = 0;
    int fsd_cnt = 0;
    int fs_cnt  = 0;
    int vs_low  = 0;
    int hs_low  = 0;

    localparam int SH = 48;
    localparam int SF = 48 * 35;

    always #5 clk = ~clk;

    board_vga_renderer dut_d (
        .clk(clk), .rst(rst), .pix_en(pe_d), .board_in(board_d),
        .hsync(hsync_d), .vsync(vsync_d), .rgb(rgb_d), .frame_start(fs_d)
    );

    board_vga_renderer #(
        .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(30), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .ORIGIN_X(7), .ORIGIN_Y(2), .TILE(5), .GAP(1)
    ) dut_s (
        .clk(clk), .rst(rst), .pix_en(pe_s), .board_in(board_s),
        .hsync(hsync_s), .vsync(vsync_s), .rgb(rgb_s), .frame_start(fs_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vec++;
        if (got !== want) begin
            miss++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step_d();
        pe_d = 1'b1;
        @(negedge clk);
        pe_d = 1'b0;
        nd++;
        if (fs_d) fsd_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic step_s();
        pe_s = 1'b1;
        @(negedge clk);
        pe_s = 1'b0;
        ns++;
        if (fs_s) fs_cnt++;
        if (!vsync_s) vs_low++;
        if (!hsync_s) hs_low++;
    endtask

    // Output after strobe n shows counter position n-2.
    task automatic goto_s(input int f, input int x, input int y);
        int tgt;
        tgt = f * SF + y * SH + x + 2;
        if (ns > tgt) check("goto_order", ns, tgt);
        while (ns < tgt) step_s();
    endtask

    task automatic px(input string tag, input int f, input int x, input int y,
                      input logic [11:0] want);
        goto_s(f, x, y);
        check(tag, rgb_s, want);
    endtask

    initial begin
        int first;
        int low;
        int per;
        int pf;
        rst = 1'b1;
        pe_d = 1'b0;
        pe_s = 1'b0;
        board_d = '0;
        board_s = '0;
        repeat (3) begin
            @(negedge clk);
            pe_d = ~pe_d;
            pe_s = ~pe_s;
        end
        @(negedge clk);
        check("rst_hsync_d", hsync_d, 1);
        check("rst_vsync_d", vsync_d, 1);
        check("rst_rgb_d", rgb_d, 0);
        check("rst_fs_d", fs_d, 0);
        check("rst_hsync_s", hsync_s, 1);
        check("rst_rgb_s", rgb_s, 0);
        pe_d = 1'b0;
        pe_s = 1'b0;
        rst = 1'b0;

        first = 0;
        for (int i = 0; i < 1000 && first == 0; i++) begin
            step_d();
            if (nd == 2) check("d_px00", rgb_d, 12'hFEE);
            if (!hsync_d) first = nd;
        end
        check("hs_first_low", first, 658);
        check("d_blank_rgb", rgb_d, 0);
        low = 1;
        per = 0;
        for (int i = 0; i < 2000; i++) begin
            step_d();
            per++;
            if (hsync_d) break;
            low++;
        end
        check("hs_low_width", low, 96);
        for (int i = 0; i < 2000; i++) begin
            step_d();
            per++;
            if (!hsync_d) break;
        end
        check("hs_period", per, 800);
        check("d_vsync_idle", vsync_d, 1);
        check("d_no_fs", fsd_cnt, 0);

        board_s[5*4 +: 4] = 4'd3;
        px("f0_r0c0", 0, 10, 5, 12'hCBA);
        px("f0_r1c1_stale", 0, 16, 11, 12'hCBA);
        px("f1_screen", 1, 3, 11, 12'hFEE);
        px("f1_border", 1, 7, 11, 12'hBAA);
        px("f1_r1c0_edge", 1, 12, 11, 12'hCBA);
        px("f1_gap", 1, 13, 11, 12'hBAA);
        px("f1_r1c1_lo", 1, 14, 11, 12'hFB7);
        px("f1_r1c1_hi", 1, 18, 11, 12'hFB7);
        px("f1_gap2", 1, 19, 11, 12'hBAA);
        px("f1_right", 1, 35, 11, 12'hFEE);
        px("f1_hblank", 1, 41, 11, 12'h000);
        check("hs_41", hsync_s, 1);
        goto_s(1, 42, 11);
        check("hs_42", hsync_s, 0);
        goto_s(1, 45, 11);
        check("hs_45", hsync_s, 0);
        goto_s(1, 46, 11);
        check("hs_46", hsync_s, 1);
        goto_s(1, 0, 12);
        board_s[0 +: 4] = 4'd1;
        board_s[15*4 +: 4] = 4'd15;
        px("f1_c15_stale", 1, 28, 23, 12'hCBA);
        px("f1_below", 1, 16, 28, 12'hFEE);
        px("f1_vblank", 1, 16, 31, 12'h000);
        check("vs_31", vsync_s, 0);
        px("f2_c0", 2, 10, 5, 12'hEED);
        px("f2_c5", 2, 16, 11, 12'hFB7);
        px("f2_c15_sat", 2, 28, 23, 12'hEC2);
        board_s[15*4 +: 4] = 4'd11;
        board_s[6*4 +: 4] = 4'd7;
        px("f3_c6", 3, 22, 11, 12'hEC7);
        check("fs_count", fs_cnt, 3);
        check("vs_low_count", vs_low, 288);
        check("hs_low_count", hs_low, 464);

        pf = 0;
        repeat (50) begin
            @(negedge clk);
            if (fs_s) pf++;
        end
        check("pause_rgb", rgb_s, 12'hEC7);
        check("pause_hsync", hsync_s, 1);
        check("pause_vsync", vsync_s, 1);
        px("f3_c15_11", 3, 28, 23, 12'hEC2);

        while (ns < 4 * SF - 1) step_s();
        repeat (50) begin
            @(negedge clk);
            if (fs_s) pf++;
        end
        check("pause_hsync_low", hsync_s, 0);
        check("pause_no_fs", pf, 0);
        step_s();
        check("fs_after_pause", fs_s, 1);
        px("f4_c5", 4, 16, 11, 12'hFB7);

        rst = 1'b1;
        pe_s = 1'b1;
        @(negedge clk);
        check("mid_rst_rgb", rgb_s, 0);
        check("mid_rst_hsync", hsync_s, 1);
        check("mid_rst_vsync", vsync_s, 1);
        check("mid_rst_fs", fs_s, 0);
        pe_s = 1'b0;
        rst = 1'b0;
        ns = 0;
        px("r0_c5_empty", 0, 16, 11, 12'hCBA);
        px("r0_c15_empty", 0, 28, 23, 12'hCBA);
        px("r1_c5", 1, 16, 11, 12'hFB7);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
